rx_tmp_buf_slab_alloc: RTL and testbench

//  Slab allocator for the TCP slow-path RX temporary payload buffer. Hands out free slab indices
//  (and slab base byte addresses) to the RX ingest stage that writes packet payloads into the temp

---
 rtl/rx_tmp_buf_slab_alloc_if.sv | 37 +++
 rtl/rx_tmp_buf_slab_alloc.sv | 149 ++++++++++++++
 tb/tb_rx_tmp_buf_slab_alloc.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_tmp_buf_slab_alloc_if.sv
// Alloc/free handshake bundle of the RX temp-buffer slab allocator.
// master = allocator side, slave = ingest/drain side.
interface rx_tmp_buf_slab_alloc_if #(
  parameter int NUM_SLABS  = 16,
  parameter int SLAB_BYTES = 2048
);
  localparam int SLAB_W = $clog2(NUM_SLABS);
  localparam int ADDR_W = SLAB_W + $clog2(SLAB_BYTES);

  logic              alloc_val;
  logic              alloc_rdy;
  logic [SLAB_W-1:0] alloc_slab;
  logic [ADDR_W-1:0] alloc_addr;
  logic              free_val;
  logic [SLAB_W-1:0] free_slab;
  logic              free_rdy;

  modport master (
    output alloc_val,
    output alloc_slab,
    output alloc_addr,
    output free_rdy,
    input  alloc_rdy,
    input  free_val,
    input  free_slab
  );

  modport slave (
    input  alloc_val,
    input  alloc_slab,
    input  alloc_addr,
    input  free_rdy,
    output alloc_rdy,
    output free_val,
    output free_slab
  );
endinterface

// File: rtl/rx_tmp_buf_slab_alloc.sv
// Slab allocator for the TCP slow-path RX temp payload buffer.
// Optional stats outputs: define RX_SLAB_ALLOC_STATS_EN.
module rx_tmp_buf_slab_alloc #(
  parameter int NUM_SLABS  = 16,
  parameter int SLAB_BYTES = 2048,
  localparam int SLAB_W    = $clog2(NUM_SLABS),
  localparam int OFF_W     = $clog2(SLAB_BYTES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rx_tmp_buf_slab_alloc_if.master bus,
  output logic [SLAB_W:0]       free_slabs,
  output logic                  init_done,
  output logic                  dbl_free_err
`ifdef RX_SLAB_ALLOC_STATS_EN
  ,
  output logic [31:0]           stat_allocs,
  output logic [31:0]           stat_frees,
  output logic [SLAB_W:0]       stat_min_free
`endif
);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  localparam logic [SLAB_W:0]   PTR_ONE = (SLAB_W+1)'(1);
  localparam logic [SLAB_W-1:0] IDX_ONE = SLAB_W'(1);
  localparam logic [SLAB_W-1:0] IDX_LST = SLAB_W'(NUM_SLABS-1);

  state_t            state;
  state_t            state_nxt;
  logic [SLAB_W:0]   wr_ptr;
  logic [SLAB_W:0]   rd_ptr;
  logic [SLAB_W-1:0] init_idx;
  logic [SLAB_W-1:0] fifo [NUM_SLABS];
  logic [NUM_SLABS-1:0] in_use;
  logic [SLAB_W:0]   free_nxt;

  logic run;
  logic init_last;
  logic a_fire;
  logic f_fire;
  logic f_ok;
  logic f_bad;

  assign run       = (state == S_RUN);
  assign init_last = (init_idx == IDX_LST);
  assign init_done = run;

  assign bus.alloc_val  = run & (free_slabs != '0);
  assign bus.alloc_slab = fifo[rd_ptr[SLAB_W-1:0]];
  assign bus.alloc_addr = {bus.alloc_slab, {OFF_W{1'b0}}};
  assign bus.free_rdy   = run;

  assign a_fire = bus.alloc_val & bus.alloc_rdy;
  assign f_fire = bus.free_val & bus.free_rdy;
  // in_use is sampled before this cycle's alloc lands
  assign f_ok   = f_fire & in_use[bus.free_slab];
  assign f_bad  = f_fire & ~in_use[bus.free_slab];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_INIT: if (init_last) state_nxt = S_RUN;
      S_RUN:  state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    free_nxt = free_slabs;
    if (!run) begin
      free_nxt = free_slabs + PTR_ONE;
    end else if (f_ok && !a_fire) begin
      free_nxt = free_slabs + PTR_ONE;
    end else if (a_fire && !f_ok) begin
      free_nxt = free_slabs - PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      init_idx     <= '0;
      in_use       <= '0;
      free_slabs   <= '0;
      dbl_free_err <= 1'b0;
      for (int i = 0; i < NUM_SLABS; i++) begin
        fifo[i] <= '0;
      end
    end else begin
      free_slabs <= free_nxt;
      if (!run) begin
        fifo[init_idx] <= init_idx;
        init_idx       <= init_idx + IDX_ONE;
        wr_ptr         <= wr_ptr + PTR_ONE;
      end else begin
        if (a_fire) begin
          rd_ptr                 <= rd_ptr + PTR_ONE;
          in_use[bus.alloc_slab] <= 1'b1;
        end
        // a valid free cannot hit a full FIFO, so no overflow guard
        if (f_ok) begin
          fifo[wr_ptr[SLAB_W-1:0]] <= bus.free_slab;
          wr_ptr                   <= wr_ptr + PTR_ONE;
          in_use[bus.free_slab]    <= 1'b0;
        end
        if (f_bad) begin
          dbl_free_err <= 1'b1;
        end
      end
    end
  end

`ifdef RX_SLAB_ALLOC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_allocs   <= '0;
      stat_frees    <= '0;
      stat_min_free <= '0;
    end else if (!run) begin
      if (init_last) begin
        stat_min_free <= (SLAB_W+1)'(NUM_SLABS);
      end
    end else begin
      if (a_fire) begin
        stat_allocs <= stat_allocs + 32'd1;
      end
      if (f_ok) begin
        stat_frees <= stat_frees + 32'd1;
      end
      if (free_nxt < stat_min_free) begin
        stat_min_free <= free_nxt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rx_tmp_buf_slab_alloc.sv
// Scoreboard bench for rx_tmp_buf_slab_alloc.
// Define RX_SLAB_ALLOC_STATS_EN to also check the stats outputs.
module tb_rx_tmp_buf_slab_alloc;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rx_tmp_buf_slab_alloc_if bus ();

  logic [4:0] free_slabs;
  logic       init_done;
  logic       dbl_free_err;
`ifdef RX_SLAB_ALLOC_STATS_EN
  logic [31:0] stat_allocs;
  logic [31:0] stat_frees;
  logic [4:0]  stat_min_free;
`endif

  rx_tmp_buf_slab_alloc dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .free_slabs   (free_slabs),
    .init_done    (init_done),
    .dbl_free_err (dbl_free_err)
`ifdef RX_SLAB_ALLOC_STATS_EN
    ,
    .stat_allocs   (stat_allocs),
    .stat_frees    (stat_frees),
    .stat_min_free (stat_min_free)
`endif
  );

  int tests  = 0;
  int failed = 0;

  int m_q[$];
  int sb[$];
  bit m_use[N];
  bit held[N];
  bit m_err;
  int m_allocs;
  int m_frees;
  int m_min;

  task automatic model_reset();
    m_q.delete();
    sb.delete();
    for (int i = 0; i < N; i++) begin
      m_q.push_back(i);
      m_use[i] = 1'b0;
      held[i]  = 1'b0;
    end
    m_err    = 1'b0;
    m_allocs = 0;
    m_frees  = 0;
    m_min    = N;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive inputs, advance the model, queue expected alloc result
  task automatic drive(input bit ar, input bit fv, input int fs);
    bit a;
    bit ok;
    int s;
    bus.alloc_rdy = ar;
    bus.free_val  = fv;
    bus.free_slab = 4'(fs);
    a  = ar && (m_q.size() > 0);
    ok = fv && m_use[fs];
    if (fv && !ok) m_err = 1'b1;
    if (a) begin
      s = m_q.pop_front();
      sb.push_back(s);
      m_use[s] = 1'b1;
      m_allocs++;
    end
    if (ok) begin
      m_q.push_back(fs);
      m_use[fs] = 1'b0;
      held[fs]  = 1'b0;
      m_frees++;
    end
    if (m_q.size() < m_min) m_min = m_q.size();
    #1;
  endtask

  task automatic do_reset();
    int n;
    bus.alloc_rdy = 1'b0;
    bus.free_val  = 1'b0;
    bus.free_slab = '0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    n = 0;
    while (!init_done && n < 40) begin
      tick();
      n++;
    end
    tests++;
    if (!init_done) begin
      failed++;
      $display("FAIL init_timeout: init_done=%0b after %0d cycles", init_done, n);
    end
    model_reset();
  endtask

  task automatic test_reset();
    int n;
    bus.alloc_rdy = 1'b0;
    bus.free_val  = 1'b0;
    bus.free_slab = '0;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.alloc_val, bus.free_rdy, init_done, dbl_free_err} !== 4'b0) begin
      failed++;
      $display("FAIL reset_flags: got %b want 0000",
               {bus.alloc_val, bus.free_rdy, init_done, dbl_free_err});
    end
    tests++;
    if (free_slabs !== 5'd0) begin
      failed++;
      $display("FAIL reset_free_slabs: got %0d want 0", free_slabs);
    end
    tick();
    rst_n = 1'b1;
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (init_done) break;
    end
    tests++;
    if (n !== 16) begin
      failed++;
      $display("FAIL init_latency: got %0d cycles want 16", n);
    end
    tests++;
    if (free_slabs !== 5'd16 || bus.alloc_val !== 1'b1) begin
      failed++;
      $display("FAIL init_free: free_slabs=%0d val=%b want 16/1", free_slabs, bus.alloc_val);
    end
    tests++;
    if (bus.alloc_slab !== 4'd0 || bus.alloc_addr !== 15'h0) begin
      failed++;
      $display("FAIL init_offer: slab=%0d addr=%h want 0/0000", bus.alloc_slab, bus.alloc_addr);
    end
    model_reset();
  endtask

  task automatic test_alloc_all();
    int e;
    for (int i = 0; i < N; i++) begin
      drive(1'b1, 1'b0, 0);
      tests++;
      if (!(bus.alloc_val && sb.size() > 0)) begin
        failed++;
        $display("FAIL alloc_all_val: val=%b pending=%0d", bus.alloc_val, sb.size());
        sb.delete();
      end else begin
        e = sb.pop_front();
        if (bus.alloc_slab !== 4'(e) || bus.alloc_addr !== 15'(e * 2048)) begin
          failed++;
          $display("FAIL alloc_all_slab: got %0d/%h want %0d/%h",
                   bus.alloc_slab, bus.alloc_addr, e, 15'(e * 2048));
        end
        held[e] = 1'b1;
      end
      tick();
    end
    drive(1'b0, 1'b0, 0);
    tests++;
    if (bus.alloc_val !== 1'b0 || free_slabs !== 5'd0) begin
      failed++;
      $display("FAIL alloc_all_empty: val=%b free=%0d want 0/0", bus.alloc_val, free_slabs);
    end
  endtask

  task automatic test_free_empty();
    drive(1'b0, 1'b1, 7);
    tests++;
    if (bus.alloc_val !== 1'b0) begin
      failed++;
      $display("FAIL free_bypass: val=%b want 0", bus.alloc_val);
    end
    tick();
    drive(1'b0, 1'b0, 0);
    tests++;
    if (bus.alloc_val !== 1'b1 || bus.alloc_slab !== 4'd7 || bus.alloc_addr !== 15'h3800) begin
      failed++;
      $display("FAIL free_offer: val=%b slab=%0d addr=%h want 1/7/3800",
               bus.alloc_val, bus.alloc_slab, bus.alloc_addr);
    end
    tests++;
    if (free_slabs !== 5'(m_q.size())) begin
      failed++;
      $display("FAIL free_count: got %0d want %0d", free_slabs, m_q.size());
    end
  endtask

  task automatic test_dbl_free();
    int e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 0);
      tests++;
      if (!(bus.alloc_val && sb.size() > 0)) begin
        failed++;
        $display("FAIL dbl_alloc_val: val=%b pending=%0d", bus.alloc_val, sb.size());
        sb.delete();
      end else begin
        e = sb.pop_front();
        if (bus.alloc_slab !== 4'(e)) begin
          failed++;
          $display("FAIL dbl_alloc_slab: got %0d want %0d", bus.alloc_slab, e);
        end
      end
      tick();
    end
    drive(1'b0, 1'b1, 1);
    tick();
    tests++;
    if (dbl_free_err !== m_err) begin
      failed++;
      $display("FAIL dbl_first_free_err: got %b want %b", dbl_free_err, m_err);
    end
    drive(1'b0, 1'b1, 1);
    tick();
    drive(1'b0, 1'b0, 0);
    tests++;
    if (dbl_free_err !== 1'b1 || dbl_free_err !== m_err) begin
      failed++;
      $display("FAIL dbl_err: got %b want 1", dbl_free_err);
    end
    tests++;
    if (free_slabs !== 5'd14 || free_slabs !== 5'(m_q.size())) begin
      failed++;
      $display("FAIL dbl_count: got %0d want 14", free_slabs);
    end
  endtask

  task automatic test_same_cycle();
    int e;
    do_reset();
    drive(1'b1, 1'b1, 0);
    tests++;
    if (!(bus.alloc_val && sb.size() > 0)) begin
      failed++;
      $display("FAIL same_val: val=%b pending=%0d", bus.alloc_val, sb.size());
      sb.delete();
    end else begin
      e = sb.pop_front();
      if (bus.alloc_slab !== 4'(e)) begin
        failed++;
        $display("FAIL same_slab: got %0d want %0d", bus.alloc_slab, e);
      end
    end
    tick();
    drive(1'b0, 1'b0, 0);
    tests++;
    if (dbl_free_err !== 1'b1 || free_slabs !== 5'd15 || bus.alloc_slab !== 4'd1) begin
      failed++;
      $display("FAIL same_state: err=%b free=%0d slab=%0d want 1/15/1",
               dbl_free_err, free_slabs, bus.alloc_slab);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    int s;
    do_reset();
    for (int i = 0; i < 108; i++) begin
      if (i < 8) begin
        drive(1'b1, 1'b0, 0);
      end else begin
        s = $urandom_range(0, N - 1);
        while (!m_use[s]) s = (s + 1) % N;
        drive(1'b1, 1'b1, s);
      end
      tests++;
      if (!(bus.alloc_val && sb.size() > 0)) begin
        failed++;
        $display("FAIL b2b_val: cyc=%0d val=%b pending=%0d", i, bus.alloc_val, sb.size());
        sb.delete();
      end else begin
        e = sb.pop_front();
        if (bus.alloc_slab !== 4'(e) || held[e]) begin
          failed++;
          $display("FAIL b2b_slab: cyc=%0d got %0d want %0d held=%b",
                   i, bus.alloc_slab, e, held[e]);
        end
        held[e] = 1'b1;
      end
      tick();
    end
    drive(1'b0, 1'b0, 0);
    tests++;
    if (free_slabs !== 5'd8 || dbl_free_err !== 1'b0) begin
      failed++;
      $display("FAIL b2b_count: free=%0d err=%b want 8/0", free_slabs, dbl_free_err);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    drive(1'b0, 1'b1, m_q[0]);
    tick();
    drive(1'b1, 1'b0, 0);
    tests++;
    if (dbl_free_err !== 1'b1) begin
      failed++;
      $display("FAIL mid_err_set: got %b want 1", dbl_free_err);
    end
`ifdef RX_SLAB_ALLOC_STATS_EN
    tests++;
    if (stat_allocs !== 32'(m_allocs - 1) || stat_frees !== 32'(m_frees)) begin
      failed++;
      $display("FAIL stats_counts: allocs=%0d frees=%0d want %0d/%0d",
               stat_allocs, stat_frees, m_allocs - 1, m_frees);
    end
    tests++;
    if (stat_min_free !== 5'd8) begin
      failed++;
      $display("FAIL stats_min: got %0d want 8", stat_min_free);
    end
`endif
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.alloc_val, bus.free_rdy, init_done, dbl_free_err} !== 4'b0 || free_slabs !== 5'd0) begin
      failed++;
      $display("FAIL mid_reset_outs: flags=%b free=%0d want 0000/0",
               {bus.alloc_val, bus.free_rdy, init_done, dbl_free_err}, free_slabs);
    end
    bus.alloc_rdy = 1'b0;
    tick();
    rst_n = 1'b1;
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (init_done) break;
    end
    tests++;
    if (n !== 16 || free_slabs !== 5'd16 || dbl_free_err !== 1'b0 || bus.alloc_slab !== 4'd0) begin
      failed++;
      $display("FAIL mid_reinit: cyc=%0d free=%0d err=%b slab=%0d want 16/16/0/0",
               n, free_slabs, dbl_free_err, bus.alloc_slab);
    end
`ifdef RX_SLAB_ALLOC_STATS_EN
    tests++;
    if (stat_allocs !== 32'd0 || stat_frees !== 32'd0 || stat_min_free !== 5'd16) begin
      failed++;
      $display("FAIL stats_reinit: %0d/%0d/%0d want 0/0/16",
               stat_allocs, stat_frees, stat_min_free);
    end
`endif
    model_reset();
  endtask

  initial begin
    bus.alloc_rdy = 1'b0;
    bus.free_val  = 1'b0;
    bus.free_slab = '0;
    test_reset();
    test_alloc_all();
    test_free_empty();
    test_dbl_free();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
